// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus register bank: move FSM states,
// default geometry and strobe-vector population checks.
package bus_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_NUM_REGS = 4;
  localparam int MAX_REGS     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } mv_state_e;

  function automatic logic [4:0] strobe_count(input logic [MAX_REGS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // True when exactly one strobe bit is set, i.e. a legal single bus driver.
  function automatic logic strobe_onehot(input logic [MAX_REGS-1:0] v);
    return strobe_count(v) == 5'd1;
  endfunction

endpackage

// File: rtl/bus_reg_cell.sv
// One WIDTH-bit bank register: loads from the bus on ld_i and presents its
// value on drv_o (zero when not enabled) for the bank's tri-state resolver.
module bus_reg_cell #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             ld_i,
  input  logic             oe_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] drv_o,
  output logic             drv_en_o
);

  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d = ld_i ? d_i : val_q;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign drv_en_o = oe_i;
  assign drv_o    = oe_i ? val_q : '0;

endmodule

// File: rtl/bus_reg_bank.sv
// Bank of NUM_REGS registers on a shared tri-state bus, with external
// load/drive strobes, contention/bad-index error flag and a move engine.
module bus_reg_bank
  import bus_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] R_in,
  input  logic [NUM_REGS-1:0] R_out,
  inout  wire  [WIDTH-1:0]    bus,
  input  logic                mv_start,
  input  logic [IDX_W-1:0]    mv_src,
  input  logic [IDX_W-1:0]    mv_dst,
  output logic                mv_busy,
  output logic                mv_done,
  output logic                err,
  input  logic                clr_err
);

  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

  mv_state_e            state_q, state_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic [IDX_W-1:0]     dst_q, dst_d;
  logic                 err_q, err_d;

  logic [MAX_REGS-1:0]  r_out_ext;
  logic                 idle;
  logic                 ext_onehot;
  logic                 contention;
  logic                 idx_ok;
  logic                 bad_start;

  logic [NUM_REGS-1:0]  ld;
  logic [NUM_REGS-1:0]  oe;
  logic [NUM_REGS-1:0]  drv_en;
  logic [WIDTH-1:0]     drv [NUM_REGS];
  logic [WIDTH-1:0]     drv_or;

  always_comb begin
    r_out_ext                 = '0;
    r_out_ext[NUM_REGS-1:0]   = R_out;
  end

  assign idle       = (state_q == IDLE);
  assign ext_onehot = strobe_onehot(r_out_ext);
  assign contention = idle && (strobe_count(r_out_ext) > 5'd1);
  assign idx_ok     = ({1'b0, mv_src} < NUM_REGS_L) && ({1'b0, mv_dst} < NUM_REGS_L);
  assign bad_start  = idle && mv_start && !idx_ok;

  // While the engine is busy the external strobes are masked off entirely.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    assign ld[gi] = idle ? R_in[gi]
                         : ((state_q == XFER) && (dst_q == IDX_W'(gi)));
    assign oe[gi] = idle ? (R_out[gi] && ext_onehot)
                         : ((state_q == XFER) && (src_q == IDX_W'(gi)));

    bus_reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk     (clk),
      .rst_n_i (rst),
      .ld_i    (ld[gi]),
      .oe_i    (oe[gi]),
      .d_i     (bus),
      .drv_o   (drv[gi]),
      .drv_en_o(drv_en[gi])
    );
  end

  always_comb begin
    drv_or = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      drv_or = drv_or | drv[i];
    end
  end

  assign bus = (|drv_en) ? drv_or : 'z;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    unique case (state_q)
      IDLE: begin
        if (mv_start && idx_ok) begin
          state_d = XFER;
          src_d   = mv_src;
          dst_d   = mv_dst;
        end
      end
      XFER:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (contention || bad_start) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  assign mv_busy = !idle;
  assign mv_done = (state_q == DONE);
  assign err     = err_q;

endmodule
